btn_debounce_rpt: RTL and testbench

- Parametrised N-channel push-button conditioner. Sits between raw board buttons (btn1/btn2-style inputs) and game logic (ship movement, fire).
- Per channel: 2-FF synchronizer, counter-based debounce FSM, one-cycle press/release strobes, and optional auto-repeat (held fire/move).
- Replaces ad hoc per-button edge logic in top with one reusable, parametrised block.

---
 rtl/btn_pkg.sv | 33 +++
 rtl/btn_debounce_rpt_if.sv | 24 ++
 rtl/btn_chan.sv | 127 ++++++++++++
 rtl/btn_debounce_rpt.sv | 51 +++++
 tb/tb_btn_debounce_rpt.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the
// push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  // Ceiling log2; returns the number of bits needed to hold values 0..v-1.
  function automatic int clog2_f(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int max3_f(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce_rpt_if.sv
// Button bus: raw levels and repeat enables in, conditioned levels/strobes out.
// Strobes are single-cycle pulses with no ready; the consumer must sample every cycle.
interface btn_debounce_rpt_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0]      btn_raw;
  logic [NCH-1:0]      rpt_en;
  logic [NCH-1:0]      level;
  logic [NCH-1:0]      press;
  logic [NCH-1:0]      release_stb;
  logic [NCH-1:0]      repeat_stb;
  logic [NCH-1:0]      fire;
  logic [NCH-1:0][1:0] state;

  modport master (
    output btn_raw, rpt_en,
    input  level, press, release_stb, repeat_stb, fire, state
  );

  modport slave (
    input  btn_raw, rpt_en,
    output level, press, release_stb, repeat_stb, fire, state
  );
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchronizer, debounce FSM and auto-repeat counter.
// All outputs are registered; nothing depends combinationally on btn_raw_i.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000,
  parameter int CNT_W          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw_i,
  input  logic       rpt_en_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       repeat_o,
  output btn_state_e state_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             first_q, first_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b00;
      state_q   <= RELEASED;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      first_q   <= 1'b1;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      first_q   <= first_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // The repeat counter defaults to cleared in first-repeat phase, so any cycle
  // that is not "held in PRESSED with repeat enabled" restarts the delay.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = '0;
    first_d   = 1'b1;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_CHK;
          dcnt_d  = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          dcnt_d  = '0;
        end else if (rpt_en_i) begin
          first_d = first_q;
          if (rcnt_q == (first_q ? RD_LAST : RP_LAST)) begin
            repeat_d = 1'b1;
            first_d  = 1'b0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = PRESSED;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
  assign state_o   = state_q;

endmodule

// File: rtl/btn_debounce_rpt.sv
// N-channel push-button conditioner: one btn_chan per button, fire = press | repeat.
// fire is an OR of registered strobes, so it adds no latency.
module btn_debounce_rpt
  import btn_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000
) (
  input logic               clk,
  input logic               reset,
  btn_debounce_rpt_if.slave btn_if
);

  localparam int CNT_W =
    clog2_f(longint'(max3_f(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD)) + 64'd1);

  logic [NCH-1:0] level_v;
  logic [NCH-1:0] press_v;
  logic [NCH-1:0] release_v;
  logic [NCH-1:0] repeat_v;
  btn_state_e     state_v [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn_raw_i(btn_if.btn_raw[i]),
      .rpt_en_i (btn_if.rpt_en[i]),
      .level_o  (level_v[i]),
      .press_o  (press_v[i]),
      .release_o(release_v[i]),
      .repeat_o (repeat_v[i]),
      .state_o  (state_v[i])
    );
    assign btn_if.state[i] = state_v[i];
  end

  assign btn_if.level       = level_v;
  assign btn_if.press       = press_v;
  assign btn_if.release_stb = release_v;
  assign btn_if.repeat_stb  = repeat_v;
  assign btn_if.fire        = press_v | repeat_v;

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Bench for btn_debounce_rpt: directed reset/latency checks, a table of
// multi-cycle button scenarios, an async reset mid-repeat, and random stimulus.
module tb_btn_debounce_rpt;

  localparam int NCH = 4;
  localparam int DT  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  btn_debounce_rpt_if #(.NCH(NCH)) bus ();

  btn_debounce_rpt #(
    .NCH           (NCH),
    .DEBOUNCE_TICKS(DT),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_if(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a level flips once the synchronized input has disagreed
  // with it for DT+1 consecutive samples; repeats fire when the count of
  // consecutive held-and-enabled cycles h satisfies h>=RD and (h-RD)%RP==0.
  logic [NCH-1:0] hist1, hist2;
  logic [NCH-1:0] m_level, m_press, m_rel, m_rpt;
  int             run  [NCH];
  int             held [NCH];

  task automatic model_reset();
    hist1 = '0; hist2 = '0;
    m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    for (int i = 0; i < NCH; i++) begin
      run[i]  = 0;
      held[i] = 0;
    end
  endtask

  task automatic model_step();
    logic s;
    logic was_pressed;
    for (int i = 0; i < NCH; i++) begin
      s           = hist2[i];
      was_pressed = m_level[i] && (run[i] == 0);
      m_press[i]  = 1'b0;
      m_rel[i]    = 1'b0;
      m_rpt[i]    = 1'b0;
      if (s != m_level[i]) begin
        run[i]++;
        if (run[i] == DT + 1) begin
          m_level[i] = s;
          run[i]     = 0;
          if (s) m_press[i] = 1'b1;
          else   m_rel[i]   = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
      if (was_pressed && s && bus.rpt_en[i]) begin
        held[i]++;
        if (held[i] >= RD && ((held[i] - RD) % RP) == 0) m_rpt[i] = 1'b1;
      end else begin
        held[i] = 0;
      end
    end
    hist2 = hist1;
    hist1 = bus.btn_raw;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("model",
          64'({bus.level, bus.press, bus.release_stb, bus.repeat_stb, bus.fire}),
          64'({m_level, m_press, m_rel, m_rpt, m_press | m_rpt}));
  endtask

  // Inputs change only at the negedge; DUT and model both advance on posedge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   en;
    int               n;
    logic [NCH-1:0]   exp_level;
    logic [NCH-1:0]   exp_press;
    logic [NCH-1:0]   exp_rel;
    logic [4*NCH-1:0] exp_rpt;
  } row_t;

  row_t rows [$];

  task automatic add_row(input logic [NCH-1:0] raw, input logic [NCH-1:0] en, input int n,
                         input logic [NCH-1:0] lvl, input logic [NCH-1:0] pr,
                         input logic [NCH-1:0] rl, input logic [4*NCH-1:0] rpt);
    row_t r;
    r.raw = raw; r.en = en; r.n = n;
    r.exp_level = lvl; r.exp_press = pr; r.exp_rel = rl; r.exp_rpt = rpt;
    rows.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*NCH-1:0] act_p, act_r, act_t, exp_p, exp_r;
    int               pc [NCH];
    int               rc [NCH];
    int               tc [NCH];
    int               hold [NCH];
    logic [NCH-1:0]   rv;
    logic             found;

    // raw, en, cycles, level, press, release, repeat counts (4 bits/channel)
    add_row(4'h1, 4'h0,  3, 4'h0, 4'h0, 4'h0, 16'h0000); // ch0 bounce
    add_row(4'h0, 4'h0,  8, 4'h0, 4'h0, 4'h0, 16'h0000);
    add_row(4'h2, 4'h0, 10, 4'h2, 4'h2, 4'h0, 16'h0000); // ch1 clean press
    add_row(4'h0, 4'h0,  2, 4'h2, 4'h0, 4'h0, 16'h0000); // ch1 dip
    add_row(4'h2, 4'h0,  8, 4'h2, 4'h0, 4'h0, 16'h0000);
    add_row(4'h0, 4'h0, 10, 4'h0, 4'h0, 4'h2, 16'h0000); // ch1 release
    add_row(4'h4, 4'h4, 30, 4'h4, 4'h4, 4'h0, 16'h0500); // ch2 repeats 17,20,23,26,29
    add_row(4'h4, 4'h0, 10, 4'h4, 4'h0, 4'h0, 16'h0000);
    add_row(4'h4, 4'h4,  8, 4'h4, 4'h0, 4'h0, 16'h0000);
    add_row(4'h4, 4'h0,  1, 4'h4, 4'h0, 4'h0, 16'h0000);
    add_row(4'h4, 4'h4, 12, 4'h4, 4'h0, 4'h0, 16'h0100);
    add_row(4'h0, 4'h0, 10, 4'h0, 4'h0, 4'h4, 16'h0000);
    add_row(4'h4, 4'h0, 30, 4'h4, 4'h4, 4'h0, 16'h0000); // repeat disabled
    add_row(4'h0, 4'h0, 10, 4'h0, 4'h0, 4'h4, 16'h0000);
    add_row(4'h4, 4'h4, 15, 4'h4, 4'h4, 4'h0, 16'h0000); // en drops at PRESSED cycle 8
    add_row(4'h4, 4'h0,  1, 4'h4, 4'h0, 4'h0, 16'h0000);
    add_row(4'h4, 4'h4, 12, 4'h4, 4'h0, 4'h0, 16'h0100); // first repeat at cycle 19
    add_row(4'h0, 4'h0, 10, 4'h0, 4'h0, 4'h4, 16'h0000);
    add_row(4'hF, 4'h0, 10, 4'hF, 4'hF, 4'h0, 16'h0000); // simultaneous press
    add_row(4'h0, 4'h0, 10, 4'h0, 4'h0, 4'hF, 16'h0000); // simultaneous release

    // Reset held with buttons pressed
    bus.btn_raw = 4'hF;
    bus.rpt_en  = 4'h0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_outputs",
            64'({bus.level, bus.press, bus.release_stb, bus.repeat_stb, bus.fire}), 64'd0);
      check("rst_state", 64'(bus.state), 64'd0);
    end
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("rst_rel_level", 64'(bus.level), (e >= 7) ? 64'hF : 64'h0);
      check("rst_rel_press", 64'(bus.press), (e == 7) ? 64'hF : 64'h0);
    end

    // Clean restart for the scenario table
    reset = 1'b0;
    bus.btn_raw = 4'h0;
    tick();
    tick();
    reset = 1'b1;

    foreach (rows[k]) begin
      bus.btn_raw = rows[k].raw;
      bus.rpt_en  = rows[k].en;
      for (int i = 0; i < NCH; i++) begin
        pc[i] = 0; rc[i] = 0; tc[i] = 0;
      end
      for (int c = 0; c < rows[k].n; c++) begin
        tick();
        for (int i = 0; i < NCH; i++) begin
          pc[i] += int'(bus.press[i]);
          rc[i] += int'(bus.release_stb[i]);
          tc[i] += int'(bus.repeat_stb[i]);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        act_p[4*i +: 4] = 4'(pc[i]);
        act_r[4*i +: 4] = 4'(rc[i]);
        act_t[4*i +: 4] = 4'(tc[i]);
        exp_p[4*i +: 4] = {3'b000, rows[k].exp_press[i]};
        exp_r[4*i +: 4] = {3'b000, rows[k].exp_rel[i]};
      end
      check($sformatf("row%0d_level", k), 64'(bus.level), 64'(rows[k].exp_level));
      check($sformatf("row%0d_press", k), 64'(act_p), 64'(exp_p));
      check($sformatf("row%0d_release", k), 64'(act_r), 64'(exp_r));
      check($sformatf("row%0d_repeat", k), 64'(act_t), 64'(rows[k].exp_rpt));
    end

    // Async reset mid-repeat on ch3, asserted and released off the clock edge
    bus.btn_raw = 4'h8;
    bus.rpt_en  = 4'h8;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.repeat_stb[3]) begin
        found = 1'b1;
        break;
      end
    end
    check("ch3_repeat_seen", 64'(found), 64'd1);
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_outputs",
          64'({bus.level, bus.press, bus.release_stb, bus.repeat_stb, bus.fire}), 64'd0);
    check("async_rst_state", 64'(bus.state), 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_strobes", 64'({bus.press, bus.release_stb, bus.repeat_stb}), 64'd0);
    for (int c = 0; c < 10; c++) tick();
    check("post_rst_repress", 64'(bus.level), 64'h8);

    // Random button activity with occasional repeat-enable changes
    rv = '0;
    for (int i = 0; i < NCH; i++) hold[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (hold[i] == 0) begin
          rv[i]   = ~rv[i];
          hold[i] = int'($urandom_range(1, 30));
        end else begin
          hold[i]--;
        end
      end
      bus.btn_raw = rv;
      if ($urandom_range(0, 15) == 0) bus.rpt_en = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
